// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, with borrow out bo.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, behind valid/ready operand and result ports.
// Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bOut_q, bOut_d;
    logic             cellD, cellBo;
    logic             lastBit, accept;

    full_subtractor uCell (
        .a_i  (aShift_q[0]),
        .b_i  (bShift_q[0]),
        .bi_i (borrow_q),
        .d_o  (cellD),
        .bo_o (cellBo)
    );

    assign lastBit = (bitCnt_q == LAST_BIT);
    assign accept  = (state_q == S_IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_SHIFT;
            S_SHIFT: if (lastBit)   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Difference bits enter the top of the minuend register as it empties, so after
    // WIDTH shifts it holds the full result; it is copied out only on the final bit.
    always_comb begin
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        borrow_d = borrow_q;
        bitCnt_d = bitCnt_q;
        diff_d   = diff_q;
        bOut_d   = bOut_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    aShift_d = a;
                    bShift_d = b;
                    borrow_d = b_in;
                    bitCnt_d = '0;
                end
            end
            S_SHIFT: begin
                aShift_d = {cellD, aShift_q[WIDTH-1:1]};
                bShift_d = {1'b0, bShift_q[WIDTH-1:1]};
                borrow_d = cellBo;
                if (lastBit) begin
                    diff_d = {cellD, aShift_q[WIDTH-1:1]};
                    bOut_d = cellBo;
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aShift_q <= '0;
            bShift_q <= '0;
            borrow_q <= 1'b0;
            bitCnt_q <= '0;
            diff_q   <= '0;
            bOut_q   <= 1'b0;
        end else begin
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            borrow_q <= borrow_d;
            bitCnt_q <= bitCnt_d;
            diff_q   <= diff_d;
            bOut_q   <= bOut_d;
        end
    end

    assign diff  = diff_q;
    assign b_out = bOut_q;

`ifdef SERIAL_SUB_OVF_EN
    logic aMsb_q, aMsb_d;
    logic bMsb_q, bMsb_d;
    logic ovf_q, ovf_d;

    // Operand MSBs are captured at accept because the shift registers lose them.
    always_comb begin
        aMsb_d = aMsb_q;
        bMsb_d = bMsb_q;
        ovf_d  = ovf_q;
        if (accept) begin
            aMsb_d = a[WIDTH-1];
            bMsb_d = b[WIDTH-1];
        end
        if ((state_q == S_SHIFT) && lastBit) begin
            ovf_d = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aMsb_q <= 1'b0;
            bMsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            aMsb_q <= aMsb_d;
            bMsb_q <= bMsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Table-driven, scoreboarded bench for serial_subtractor (WIDTH=8), plus backpressure and mid-shift reset sequences.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    int   nChecks = 0;
    int   nFails  = 0;
    vec_t sbQ[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    // Without the overflow option the flag must read 0 regardless of operands.
    function automatic logic expOvf(input vec_t v);
`ifdef SERIAL_SUB_OVF_EN
        return v.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for in_ready at a falling edge, drives operands, records the expected result.
    task automatic applyStimulus(input vec_t v);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready wait", in_ready, 1);
        a        = v.a;
        b        = v.b;
        b_in     = v.bin;
        in_valid = 1'b1;
        sbQ.push_back(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accept edge; measures latency, pops the scoreboard, checks and retires.
    task automatic collectResult(input string tag);
        int   cycles = 0;
        bit   sawReady = 1'b0;
        vec_t e;
        @(negedge clk);
        while (!out_valid && cycles < 30) begin
            if (in_ready) sawReady = 1'b1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, cycles, WIDTH);
        checkOutput({tag, " in_ready during SHIFT"}, sawReady, 0);
        if (sbQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s scoreboard: got result, expected queue non-empty", tag);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, " diff"}, diff, e.diff);
            checkOutput({tag, " b_out"}, b_out, e.bout);
            checkOutput({tag, " ovf"}, ovf, expOvf(e));
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " out_valid after retire"}, out_valid, 0);
            checkOutput({tag, " diff held"}, diff, e.diff);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        int   cycles;
        bit   sawReady;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{8'd20,  8'd8,    1'b0, 8'd12,  1'b0, 1'b0};
        vecs[1] = '{8'd8,   8'd12,   1'b0, 8'hFC,  1'b1, 1'b0};
        vecs[2] = '{8'd33,  8'd10,   1'b1, 8'd22,  1'b0, 1'b0};
        vecs[3] = '{8'd0,   8'd0,    1'b1, 8'd255, 1'b1, 1'b0};
        vecs[4] = '{8'h80,  8'h01,   1'b0, 8'h7F,  1'b0, 1'b1};
        vecs[5] = '{8'h05,  8'h03,   1'b0, 8'h02,  1'b0, 1'b0};
        vecs[6] = '{8'h7F,  8'hFF,   1'b0, 8'h80,  1'b1, 1'b1};
        vecs[7] = '{8'hFF,  8'hFF,   1'b1, 8'hFF,  1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset diff", diff, 0);
        checkOutput("reset b_out", b_out, 0);
        checkOutput("reset ovf", ovf, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            collectResult($sformatf("vec%0d", i));
        end

        // Backpressure: result held in DONE while stray operand pulses are ignored.
        out_ready = 1'b0;
        v = '{8'd20, 8'd8, 1'b0, 8'd12, 1'b0, 1'b0};
        applyStimulus(v);
        cycles   = 0;
        sawReady = 1'b0;
        @(negedge clk);
        while (!out_valid && cycles < 30) begin
            in_valid = cycles[0];
            a        = 8'hAA;
            b        = 8'h11;
            b_in     = 1'b1;
            if (in_ready) sawReady = 1'b1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput("bp latency", cycles, WIDTH);
        checkOutput("bp in_ready during SHIFT", sawReady, 0);
        v = sbQ.pop_front();
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp hold%0d out_valid", k), out_valid, 1);
            checkOutput($sformatf("bp hold%0d diff", k), diff, v.diff);
            checkOutput($sformatf("bp hold%0d b_out", k), b_out, v.bout);
            checkOutput($sformatf("bp hold%0d in_ready", k), in_ready, 0);
        end

        // Retire and offer new operands on the same edge: retire only, accept one cycle later.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'd1;
        b         = 8'd0;
        b_in      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("retire+offer out_valid", out_valid, 0);
        checkOutput("retire+offer in_ready", in_ready, 1);
        checkOutput("retire+offer diff held", diff, 12);
        v = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
        sbQ.push_back(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collectResult("post-retire");

        // Reset with bit 3 about to be processed discards the partial result.
        v = '{8'd50, 8'd7, 1'b0, 8'd43, 1'b0, 1'b0};
        applyStimulus(v);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        checkOutput("midreset in_ready", in_ready, 1);
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset diff", diff, 0);
        checkOutput("midreset b_out", b_out, 0);
        repeat (10) @(negedge clk);
        checkOutput("midreset no stale result", out_valid, 0);

        v = '{8'd2, 8'd8, 1'b0, 8'd250, 1'b1, 1'b0};
        applyStimulus(v);
        collectResult("after reset");

        checkOutput("scoreboard drained", sbQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
